// File: rtl/instr_mem_responder_if.sv
// rtl/instr_mem_responder_if.sv - CPU fetch port and word preload port of the instruction memory
interface instr_mem_responder_if;
  logic        READ;
  logic [31:0] ADDRESS;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
  logic        INSTR_VALID;
  logic        LOAD_EN;
  logic [31:0] LOAD_ADDR;
  logic [31:0] LOAD_DATA;

  modport master (
    output READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    input  INSTRUCTION, BUSYWAIT, INSTR_VALID
  );

  modport slave (
    input  READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    output INSTRUCTION, BUSYWAIT, INSTR_VALID
  );
endinterface

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - multi-cycle instruction memory with READ/BUSYWAIT handshake and word preload
module instr_mem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  instr_mem_responder_if.slave   bus
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  count, count_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              load_we;
  logic              fetch_fire;
  logic [31:0]       rd_word;
  logic [WORD_W-1:0] wr_idx;

  logic [7:0] mem [MEM_BYTES];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ADDRESS[31:ADDR_W], bus.ADDRESS[1:0],
                              bus.LOAD_ADDR[31:ADDR_W], bus.LOAD_ADDR[1:0]};

  assign wr_idx  = bus.LOAD_ADDR[ADDR_W-1:2];
  assign rd_word = {mem[{addr_q, 2'd3}], mem[{addr_q, 2'd2}],
                    mem[{addr_q, 2'd1}], mem[{addr_q, 2'd0}]};

  // Gated by RESET so a stalled CPU sees no BUSYWAIT while the block is held in reset.
  assign bus.BUSYWAIT = RESET & (((state == IDLE) & bus.READ) | (state == BUSY));

  always_comb begin
    state_d    = state;
    count_d    = count;
    addr_d     = addr_q;
    load_we    = 1'b0;
    fetch_fire = 1'b0;
    case (state)
      IDLE: begin
        // A preload wins the edge; a simultaneous READ is taken on the following edge.
        if (bus.LOAD_EN) begin
          load_we = 1'b1;
        end else if (bus.READ) begin
          addr_d  = bus.ADDRESS[ADDR_W-1:2];
          count_d = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (count != '0) begin
          count_d = count - 1'b1;
        end else begin
          fetch_fire = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= IDLE;
      count           <= '0;
      addr_q          <= '0;
      bus.INSTRUCTION <= '0;
      bus.INSTR_VALID <= 1'b0;
    end else begin
      state           <= state_d;
      count           <= count_d;
      addr_q          <= addr_d;
      bus.INSTR_VALID <= fetch_fire;
      if (fetch_fire) begin
        bus.INSTRUCTION <= rd_word;
      end
    end
  end

  // Storage is deliberately not reset; program contents survive a CPU reset.
  always_ff @(posedge CLK) begin
    if (load_we && RESET) begin
      mem[{wr_idx, 2'd0}] <= bus.LOAD_DATA[7:0];
      mem[{wr_idx, 2'd1}] <= bus.LOAD_DATA[15:8];
      mem[{wr_idx, 2'd2}] <= bus.LOAD_DATA[23:16];
      mem[{wr_idx, 2'd3}] <= bus.LOAD_DATA[31:24];
    end
  end

endmodule
